// File: rtl/mips_ctrl_pkg.sv
// Shared decode constants for the MIPS ID stage: opcodes, ALU op classes,
// sign-extender mode codes, control word layout and sequencer states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  // Loads are 100xxx and stores 101xxx; matched on opcode[5:3].
  localparam logic [2:0] OP_LOAD_HI  = 3'b100;
  localparam logic [2:0] OP_STORE_HI = 3'b101;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_NONE = 2'b11;

  typedef struct packed {
    logic       ex_valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } seq_state_e;

endpackage

// File: rtl/id_control_sequencer_if.sv
// ID-stage control bus between the pipeline/debug unit and the sequencer.
interface id_control_sequencer_if #(
  parameter int unsigned NB_INSTR = 32
) ();
  logic                i_enable;
  logic                i_valid;
  logic [NB_INSTR-1:0] i_instruction;
  logic                i_stall;
  logic                i_flush;
  logic [1:0]          o_ExtensionMode;
  logic                o_ex_valid;
  logic                o_RegWrite;
  logic                o_MemRead;
  logic                o_MemWrite;
  logic                o_MemToReg;
  logic                o_ALUSrc;
  logic                o_RegDst;
  logic                o_Branch;
  logic [2:0]          o_ALUOp;
  logic                o_illegal;
  logic                o_fetch_hold;
  logic                o_halted;

  modport master (
    output i_enable, i_valid, i_instruction, i_stall, i_flush,
    input  o_ExtensionMode, o_ex_valid, o_RegWrite, o_MemRead, o_MemWrite,
           o_MemToReg, o_ALUSrc, o_RegDst, o_Branch, o_ALUOp, o_illegal,
           o_fetch_hold, o_halted
  );

  modport slave (
    input  i_enable, i_valid, i_instruction, i_stall, i_flush,
    output o_ExtensionMode, o_ex_valid, o_RegWrite, o_MemRead, o_MemWrite,
           o_MemToReg, o_ALUSrc, o_RegDst, o_Branch, o_ALUOp, o_illegal,
           o_fetch_hold, o_halted
  );
endinterface

// File: rtl/id_opcode_decoder.sv
// Pure combinational opcode decode: extension mode, control word,
// illegal-opcode and HALT flags.
module id_opcode_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output logic [1:0] o_ext_mode,
  output ctrl_t      o_ctrl,
  output logic       o_illegal,
  output logic       o_is_halt
);

  // Map each opcode class to its extension mode and EX/MEM/WB control.
  always_comb begin
    o_ext_mode = EXT_NONE;
    o_ctrl     = '0;
    o_illegal  = 1'b0;
    o_is_halt  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.ex_valid  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      OP_J, OP_JAL: o_ctrl.ex_valid = 1'b1;
      OP_BEQ, OP_BNE: begin
        o_ext_mode      = EXT_SIGN;
        o_ctrl.ex_valid = 1'b1;
        o_ctrl.branch   = 1'b1;
        o_ctrl.alu_op   = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        o_ext_mode       = EXT_SIGN;
        o_ctrl.ex_valid  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = (i_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_ext_mode       = EXT_ZERO;
        o_ctrl.ex_valid  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = (i_opcode == OP_ANDI) ? ALU_AND :
                           (i_opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        o_ext_mode       = EXT_LUI;
        o_ctrl.ex_valid  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALU_LUI;
      end
      OP_HALT: o_is_halt = 1'b1;
      default: begin
        if (i_opcode[5:3] == OP_LOAD_HI) begin
          o_ext_mode        = EXT_SIGN;
          o_ctrl.ex_valid   = 1'b1;
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.mem_read   = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.alu_src    = 1'b1;
          o_ctrl.alu_op     = ALU_ADD;
        end else if (i_opcode[5:3] == OP_STORE_HI) begin
          o_ext_mode       = EXT_SIGN;
          o_ctrl.ex_valid  = 1'b1;
          o_ctrl.mem_write = 1'b1;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.alu_op    = ALU_ADD;
        end else begin
          o_illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/id_control_sequencer.sv
// ID-stage controller: registers the control word into ID/EX with bubble
// insertion on stall/flush, and sequences the HALT drain.
module id_control_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned NB_INSTR     = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic                  i_clock,
  input logic                  i_reset,
  id_control_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  logic [1:0] dec_ext;
  ctrl_t      dec_ctrl;
  logic       dec_illegal;
  logic       dec_is_halt;

  id_opcode_decoder u_decoder (
    .i_opcode  (bus.i_instruction[NB_INSTR-1 -: 6]),
    .o_ext_mode(dec_ext),
    .o_ctrl    (dec_ctrl),
    .o_illegal (dec_illegal),
    .o_is_halt (dec_is_halt)
  );

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic             fetch_hold_q, fetch_hold_d;
  logic             halted_q, halted_d;

  // Next-state: everything holds when disabled; otherwise a bubble is the
  // default and only RUN with an accepted legal instruction loads a word.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ctrl_d       = ctrl_q;
    illegal_d    = illegal_q;
    fetch_hold_d = fetch_hold_q;
    halted_d     = halted_q;
    if (bus.i_enable) begin
      ctrl_d    = '0;
      illegal_d = 1'b0;
      case (state_q)
        ST_RUN: begin
          if (!bus.i_flush && !bus.i_stall && bus.i_valid) begin
            if (dec_is_halt) begin
              fetch_hold_d = 1'b1;
              cnt_d        = CNT_INIT;
              state_d      = ST_DRAIN;
            end else if (dec_illegal) begin
              illegal_d = 1'b1;
            end else begin
              ctrl_d = dec_ctrl;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset overrides enable.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      ctrl_q       <= '0;
      illegal_q    <= 1'b0;
      fetch_hold_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      illegal_q    <= illegal_d;
      fetch_hold_q <= fetch_hold_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.o_ExtensionMode = dec_ext;
  assign bus.o_ex_valid      = ctrl_q.ex_valid;
  assign bus.o_RegWrite      = ctrl_q.reg_write;
  assign bus.o_MemRead       = ctrl_q.mem_read;
  assign bus.o_MemWrite      = ctrl_q.mem_write;
  assign bus.o_MemToReg      = ctrl_q.mem_to_reg;
  assign bus.o_ALUSrc        = ctrl_q.alu_src;
  assign bus.o_RegDst        = ctrl_q.reg_dst;
  assign bus.o_Branch        = ctrl_q.branch;
  assign bus.o_ALUOp         = ctrl_q.alu_op;
  assign bus.o_illegal       = illegal_q;
  assign bus.o_fetch_hold    = fetch_hold_q;
  assign bus.o_halted        = halted_q;

endmodule
